riscv_trace_capture: RTL

- Passive trace recorder that sits beside the multicycle RISC-V core (`principal`).
- It samples the core's control-state output and datapath buses, and records one entry every time the control FSM changes state.
- Entries are buffered in a FIFO and drained through a valid/ready read port to a host, UART bridge or bench.
- It also bounds a run by cycle count and raises `done` when the window ends.

---
 rtl/riscv_trace_capture.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_trace_capture.sv
// ============================================================================
// Module      : riscv_trace_capture
// Description : Passive trace recorder for the multicycle RISC-V core. Logs
//               one entry per control-state change into a FIFO and drains it
//               through a valid/ready port. Optional macro TRACE_OPERANDS_EN
//               adds ALU operand A/B to every entry.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module riscv_trace_capture #(
  parameter int STATE_W    = 5,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 64,
  parameter int STAMP_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [STATE_W-1:0]       state_in,
  input  logic [DATA_W-1:0]        wd_in,
  input  logic [DATA_W-1:0]        alu_a_in,
  input  logic [DATA_W-1:0]        alu_b_in,
  input  logic [DATA_W-1:0]        alu_y_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [STAMP_W-1:0]       rd_stamp,
  output logic [STATE_W-1:0]       rd_state,
  output logic [DATA_W-1:0]        rd_wd,
  output logic [DATA_W-1:0]        rd_alu_y,
`ifdef TRACE_OPERANDS_EN
  output logic [DATA_W-1:0]        rd_alu_a,
  output logic [DATA_W-1:0]        rd_alu_b,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     capturing,
  output logic                     done
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0]    c_depth = c_cw'(DEPTH);
  localparam logic [STAMP_W-1:0] c_last  = STAMP_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start;

  logic [STAMP_W-1:0] r_cnt;
  logic [STATE_W-1:0] r_prev;
  logic               r_first;
  logic               r_ovf;
  logic [c_aw-1:0]    r_wptr;
  logic [c_aw-1:0]    r_rptr;
  logic [c_cw-1:0]    r_count;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr_en;
  logic w_drop;

  logic [STAMP_W-1:0] r_mem_stamp [DEPTH];
  logic [STATE_W-1:0] r_mem_state [DEPTH];
  logic [DATA_W-1:0]  r_mem_wd    [DEPTH];
  logic [DATA_W-1:0]  r_mem_y     [DEPTH];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_state_nxt = S_CAP;
          w_start     = 1'b1;
        end
      end
      S_CAP: begin
        if (r_cnt == c_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (arm) begin
          w_state_nxt = S_CAP;
          w_start     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------- FIFO control
  assign rd_valid = (r_count != '0);
  assign w_full   = (r_count == c_depth);
  assign w_push   = (r_state == S_CAP) && (r_first || (state_in != r_prev));
  // The arming edge flushes the FIFO, so a coincident pop must not count.
  assign w_pop    = rd_valid && rd_ready && !w_start;
  assign w_wr_en  = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_prev  <= '0;
      r_first <= 1'b0;
      r_ovf   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_first <= 1'b1;
      r_ovf   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (r_state == S_CAP) begin
        r_cnt   <= r_cnt + STAMP_W'(1);
        r_prev  <= state_in;
        r_first <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_wr_en) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_aw'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_stamp[r_wptr] <= r_cnt;
      r_mem_state[r_wptr] <= state_in;
      r_mem_wd[r_wptr]    <= wd_in;
      r_mem_y[r_wptr]     <= alu_y_in;
    end
  end

  // Head fields are forced to zero when empty so stale slots never leak out.
  assign rd_stamp = rd_valid ? r_mem_stamp[r_rptr] : '0;
  assign rd_state = rd_valid ? r_mem_state[r_rptr] : '0;
  assign rd_wd    = rd_valid ? r_mem_wd[r_rptr]    : '0;
  assign rd_alu_y = rd_valid ? r_mem_y[r_rptr]     : '0;

`ifdef TRACE_OPERANDS_EN
  logic [DATA_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_b [DEPTH];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_a[r_wptr] <= alu_a_in;
      r_mem_b[r_wptr] <= alu_b_in;
    end
  end

  assign rd_alu_a = rd_valid ? r_mem_a[r_rptr] : '0;
  assign rd_alu_b = rd_valid ? r_mem_b[r_rptr] : '0;
`else
  logic w_unused_ops;
  assign w_unused_ops = ^{alu_a_in, alu_b_in};
`endif

  assign count     = r_count;
  assign overflow  = r_ovf;
  assign capturing = (r_state == S_CAP);
  assign done      = (r_state == S_DONE);

endmodule

`default_nettype wire
